// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
//   Round-robin write arbiter in front of one shared WIDTH-bit register.
//   Each requester holds req[i] with its word on wdata[i*WIDTH +: WIDTH].
//   The winner's word is loaded into q on the granting edge, and gnt pulses
//   for one cycle. An ACK turnaround cycle follows every unlocked grant.
//
//   Optional feature macro: SHARED_REG_ARBITER_LOCK_EN
//     When defined, a granted requester that also holds lock[i] keeps
//     ownership and writes every cycle, for up to LOCK_MAX writes.
//     When undefined, the lock port is present but ignored.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req        per-requester write request, held until granted
//   wdata      packed requester words
//   lock       per-requester burst lock (LOCK_EN builds only)
//   q          shared register contents
//   gnt        one-hot grant (registered)
//   owner      index of the last granted requester
//   wr_strobe  high for one cycle after each edge that loaded q
//   busy       high whenever the arbiter is not IDLE
module shared_reg_arbiter #(
    parameter int WIDTH    = 8,
    parameter int NREQ     = 4,
    parameter int LOCK_MAX = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    input  logic [NREQ-1:0]       lock,
    output logic [WIDTH-1:0]      q,
    output logic [NREQ-1:0]       gnt,
    output logic [2:0]            owner,
    output logic                  wr_strobe,
    output logic                  busy
);

    localparam int PW = $clog2(NREQ);

`ifdef SHARED_REG_ARBITER_LOCK_EN
    typedef enum logic [1:0] {IDLE, ACK, LOCKED} state_t;
    localparam int CW = $clog2(LOCK_MAX + 1);
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] own_data;
    logic             own_hold;
`else
    typedef enum logic {IDLE, ACK} state_t;
    logic unused_lock;
    assign unused_lock = ^lock;
`endif

    state_t           state;
    logic [2:0]       ptr;
    logic             found;
    logic [2:0]       win;
    logic [2:0]       ptr_next;
    logic [WIDTH-1:0] win_data;
    int unsigned      idx;

    // Search upward from ptr, wrapping modulo NREQ; the first set bit wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= 32'(NREQ)) begin
                idx = idx - 32'(NREQ);
            end
            if (!found && req[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = 3'(idx);
            end
        end
    end

    always_comb begin
        win_data = wdata[32'(win)*WIDTH +: WIDTH];
        ptr_next = (win == 3'(NREQ - 1)) ? 3'd0 : win + 3'd1;
    end

`ifdef SHARED_REG_ARBITER_LOCK_EN
    always_comb begin
        own_data = wdata[32'(owner)*WIDTH +: WIDTH];
        own_hold = req[owner[PW-1:0]] && lock[owner[PW-1:0]];
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            q         <= '0;
            gnt       <= '0;
            owner     <= '0;
            wr_strobe <= 1'b0;
            busy      <= 1'b0;
            ptr       <= '0;
`ifdef SHARED_REG_ARBITER_LOCK_EN
            count     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        q         <= win_data;
                        gnt       <= NREQ'(1) << win;
                        owner     <= win;
                        wr_strobe <= 1'b1;
                        busy      <= 1'b1;
                        ptr       <= ptr_next;
`ifdef SHARED_REG_ARBITER_LOCK_EN
                        if (lock[win[PW-1:0]]) begin
                            state <= LOCKED;
                            count <= CW'(1);
                        end else begin
                            state <= ACK;
                        end
`else
                        state     <= ACK;
`endif
                    end else begin
                        gnt       <= '0;
                        wr_strobe <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                ACK: begin
                    gnt       <= '0;
                    wr_strobe <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
`ifdef SHARED_REG_ARBITER_LOCK_EN
                LOCKED: begin
                    if (own_hold && (count < CW'(LOCK_MAX))) begin
                        q         <= own_data;
                        wr_strobe <= 1'b1;
                        count     <= count + CW'(1);
                    end else begin
                        // Exit edge: ownership released, q keeps the last word.
                        gnt       <= '0;
                        wr_strobe <= 1'b0;
                        busy      <= 1'b0;
                        count     <= '0;
                        state     <= IDLE;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
module tb_shared_reg_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       lock;
    logic [WIDTH-1:0]      q;
    logic [NREQ-1:0]       gnt;
    logic [2:0]            owner;
    logic                  wr_strobe;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic [NREQ-1:0]  gnt;
        logic [2:0]       owner;
    } exp_t;

    exp_t sb[$];

    shared_reg_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LOCK_MAX(4)) dut (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata), .lock(lock),
        .q(q), .gnt(gnt), .owner(owner), .wr_strobe(wr_strobe), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input int idx, input logic [WIDTH-1:0] val);
        exp_t e;
        e.q     = val;
        e.gnt   = NREQ'(1) << idx;
        e.owner = 3'(idx);
        sb.push_back(e);
    endtask

    task automatic chk_idle(input string name, input logic [WIDTH-1:0] qv);
        chk({name, "_gnt"}, 32'(gnt), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_strobe"}, 32'(wr_strobe), 32'd0);
        chk({name, "_q"}, 32'(q), 32'(qv));
    endtask

    // One unlocked tenure: grant edge, then ACK edge. wdata is scrambled
    // after the grant to show it is sampled only on the granting edge.
    task automatic grant_one(input int idx, input logic [WIDTH-1:0] val,
                             input logic [NREQ-1:0] req_after);
        wdata[idx*WIDTH +: WIDTH] = val;
        expect_write(idx, val);
        tick();
        chk("grant_busy", 32'(busy), 32'd1);
        req   = req_after;
        wdata = $urandom;
        tick();
        chk_idle("ack", val);
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
        if (wr_strobe === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'(q), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("wr_q", 32'(q), 32'(e.q));
                chk("wr_gnt", 32'(gnt), 32'(e.gnt));
                chk("wr_owner", 32'(owner), 32'(e.owner));
            end
        end
    end

    initial begin
        reset = 1'b1;
        req   = 4'b1111;
        lock  = '0;
        wdata = 32'hDEAD_BEEF;

        // Reset held two cycles with all requests pending.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_idle("reset", 8'h00);
            chk("reset_owner", 32'(owner), 32'd0);
        end
        reset = 1'b0;

        // Round robin 0,1,2,3, each dropping its request after its grant.
        grant_one(0, 8'h10, 4'b1110);
        grant_one(1, 8'h21, 4'b1100);
        grant_one(2, 8'h32, 4'b1000);
        grant_one(3, 8'h43, 4'b0000);

        // ptr back at 0: 0 then 3.
        req = 4'b1001;
        grant_one(0, 8'h54, 4'b1000);
        grant_one(3, 8'h65, 4'b0000);

        // Single request.
        req = 4'b0100;
        grant_one(2, 8'hA5, 4'b0000);

        // No requests: q holds.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_idle("idle_hold", 8'hA5);
        end

        // ptr=3: search wraps past 3,0 to find 1; then ptr=2 picks 3, wraps to 0.
        req = 4'b0010;
        grant_one(1, 8'h77, 4'b0000);
        req = 4'b1001;
        grant_one(3, 8'h88, 4'b0001);
        grant_one(0, 8'h99, 4'b0000);

`ifdef SHARED_REG_ARBITER_LOCK_EN
        // Locked burst, LOCK_MAX=4, with requester 2 pending throughout.
        reset = 1'b1;
        tick();
        chk_idle("lock_pre_reset", 8'h00);
        reset = 1'b0;
        req   = 4'b0110;
        lock  = 4'b0010;
        wdata[2*WIDTH +: WIDTH] = 8'hB2;
        for (int n = 1; n <= 4; n++) begin
            wdata[1*WIDTH +: WIDTH] = 8'(n);
            expect_write(1, 8'(n));
            tick();
            chk("lock_gnt", 32'(gnt), 32'h2);
            chk("lock_busy", 32'(busy), 32'd1);
        end
        wdata[1*WIDTH +: WIDTH] = 8'h05;
        tick();
        chk_idle("lock_release", 8'h04);
        req  = 4'b0100;
        lock = 4'b0000;
        grant_one(2, 8'hB2, 4'b0000);

        // Reset during the second locked write: that write is suppressed.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req   = 4'b0010;
        lock  = 4'b0010;
        wdata[1*WIDTH +: WIDTH] = 8'h11;
        expect_write(1, 8'h11);
        tick();
        wdata[1*WIDTH +: WIDTH] = 8'h22;
        reset = 1'b1;
        tick();
        chk_idle("mid_lock_reset", 8'h00);
        chk("mid_lock_reset_owner", 32'(owner), 32'd0);
        reset = 1'b0;
        req   = 4'b0000;
        lock  = 4'b0000;
        tick();
        chk_idle("after_reset", 8'h00);
        // ptr was cleared: requester 1 wins over 2 from ptr 0.
        req = 4'b0110;
        grant_one(1, 8'h3C, 4'b0100);
        grant_one(2, 8'h4D, 4'b0000);
`else
        // Lock input ignored: a grant with lock high still takes ACK.
        req  = 4'b0001;
        lock = 4'b0001;
        grant_one(0, 8'hC3, 4'b0000);
        lock = 4'b0000;

        // Reset mid-ACK: grant, then reset on the ACK edge.
        req = 4'b0100;
        wdata[2*WIDTH +: WIDTH] = 8'h5A;
        expect_write(2, 8'h5A);
        tick();
        req   = 4'b0000;
        reset = 1'b1;
        tick();
        chk_idle("ack_reset", 8'h00);
        reset = 1'b0;
        req   = 4'b0011;
        grant_one(0, 8'h66, 4'b0010);
        grant_one(1, 8'h67, 4'b0000);
`endif

        tick();
        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
